// File: rtl/data_memory_arbiter_pkg.sv
// Shared types for the data memory arbiter: the per-requester request bundle
// and the arbitration state.
package data_memory_arbiter_pkg;

   localparam int DATA_BITS  = 10;
   localparam int MAX_ADDR_W = 30;

   typedef enum logic {
      ST_ARB    = 1'b0,
      ST_LOCKED = 1'b1
   } arb_state_t;

   typedef struct packed {
      logic [MAX_ADDR_W-1:0] addr;
      logic                  wren;
      logic [3:0]            byteena;
      logic [31:0]           wdata;
      logic                  lock;
   } mem_req_t;

   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/data_memory_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first set request
// found searching circularly upward from i_ptr.
module data_memory_arbiter_rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int PTR_W   = 1
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [PTR_W-1:0]   i_ptr,
   output logic [NUM_REQ-1:0] o_grant
);

   localparam int SUM_W = PTR_W + 1;

   logic [SUM_W-1:0] w_sum;
   logic [PTR_W-1:0] w_idx;
   logic             w_found;

   // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
   always_comb begin
      o_grant = '0;
      w_found = 1'b0;
      w_sum   = '0;
      w_idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_sum = {1'b0, i_ptr} + SUM_W'(k);
         if (w_sum >= SUM_W'(NUM_REQ)) begin
            w_sum = w_sum - SUM_W'(NUM_REQ);
         end
         w_idx = w_sum[PTR_W-1:0];
         if (!w_found && i_req[w_idx]) begin
            o_grant[w_idx] = 1'b1;
            w_found        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between NUM_REQ
// requesters, with a bus lock for atomic read-modify-write sequences.
module data_memory_arbiter
   import data_memory_arbiter_pkg::*;
#(
   parameter int NUM_REQ    = 2,
   parameter int ADDR_WIDTH = DATA_BITS - 2
) (
   input  logic                               i_clock,
   input  logic                               i_reset_n,
   input  logic [NUM_REQ-1:0]                 i_req_valid,
   output logic [NUM_REQ-1:0]                 o_req_ready,
   input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] i_req_addr,
   input  logic [NUM_REQ-1:0]                 i_req_wren,
   input  logic [NUM_REQ-1:0][3:0]            i_req_byteena,
   input  logic [NUM_REQ-1:0][31:0]           i_req_wdata,
   input  logic [NUM_REQ-1:0]                 i_req_lock,
   output logic [NUM_REQ-1:0]                 o_resp_valid,
   output logic [31:0]                        o_resp_rdata,
   output logic [ADDR_WIDTH-1:0]              o_mem_address,
   output logic [3:0]                         o_mem_byteena,
   output logic [31:0]                        o_mem_data,
   output logic                               o_mem_wren,
   input  logic [31:0]                        i_mem_q
);

   localparam int PTR_W = $clog2(NUM_REQ);

   arb_state_t         r_state;
   logic [PTR_W-1:0]   r_rr_ptr;
   logic [PTR_W-1:0]   r_lock_owner;
   logic [NUM_REQ-1:0] r_resp_valid;
   logic [31:0]        r_resp_rdata;

   mem_req_t           w_req [NUM_REQ];
   mem_req_t           w_sel;
   logic [NUM_REQ-1:0] w_arb_grant;
   logic [NUM_REQ-1:0] w_owner_oh;
   logic [NUM_REQ-1:0] w_grant;
   logic [PTR_W-1:0]   w_grant_idx;
   logic               w_handshake;
   logic               w_unused_addr;

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         w_req[i] = '{addr:    MAX_ADDR_W'(i_req_addr[i]),
                      wren:    i_req_wren[i],
                      byteena: i_req_byteena[i],
                      wdata:   i_req_wdata[i],
                      lock:    i_req_lock[i]};
      end
   end

   data_memory_arbiter_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_rr_arbiter (
      .i_req   (i_req_valid),
      .i_ptr   (r_rr_ptr),
      .o_grant (w_arb_grant)
   );

   // Grant is forced low while reset is asserted so ready and the memory
   // drive fall to zero asynchronously together with the registered outputs.
   always_comb begin
      w_owner_oh               = '0;
      w_owner_oh[r_lock_owner] = 1'b1;
      if (!i_reset_n) begin
         w_grant = '0;
      end else if (r_state == ST_LOCKED) begin
         w_grant = w_owner_oh & i_req_valid;
      end else begin
         w_grant = w_arb_grant;
      end
   end

   always_comb begin
      w_sel       = '0;
      w_grant_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_grant[i]) begin
            w_sel       = w_req[i];
            w_grant_idx = PTR_W'(i);
         end
      end
   end

   assign w_handshake   = |w_grant;
   assign o_req_ready   = w_grant;
   assign o_mem_address = w_sel.addr[ADDR_WIDTH-1:0];
   assign o_mem_byteena = w_sel.byteena;
   assign o_mem_data    = w_sel.wdata;
   assign o_mem_wren    = w_handshake & w_sel.wren;
   assign w_unused_addr = ^w_sel.addr;

   // NOTE: all state uses non-blocking assignments so each flop samples pre-edge values.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state      <= ST_ARB;
         r_rr_ptr     <= '0;
         r_lock_owner <= '0;
         r_resp_valid <= '0;
         r_resp_rdata <= '0;
      end else begin
         r_resp_valid <= w_grant;
         if (w_handshake) begin
            r_rr_ptr <= PTR_W'(wrap_inc(int'(w_grant_idx), NUM_REQ));
            if (!w_sel.wren) begin
               r_resp_rdata <= i_mem_q;
            end
         end
         case (r_state)
            ST_ARB: begin
               if (w_handshake && w_sel.lock) begin
                  r_state      <= ST_LOCKED;
                  r_lock_owner <= w_grant_idx;
               end
            end
            ST_LOCKED: begin
               if (w_handshake && !w_sel.lock) begin
                  r_state <= ST_ARB;
               end
            end
            default: r_state <= ST_ARB;
         endcase
      end
   end

   assign o_resp_valid = r_resp_valid;
   assign o_resp_rdata = r_resp_rdata;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Self-checking bench for data_memory_arbiter: directed scenarios followed by
// randomized traffic, all compared against a transaction-level reference model.
module tb_data_memory_arbiter;

   localparam int N  = 2;
   localparam int AW = 8;

   logic               clk;
   logic               rst_n;
   logic [N-1:0]       tb_valid;
   logic [N-1:0]       dut_ready;
   logic [N-1:0][AW-1:0] tb_addr;
   logic [N-1:0]       tb_wren;
   logic [N-1:0][3:0]  tb_byteena;
   logic [N-1:0][31:0] tb_wdata;
   logic [N-1:0]       tb_lock;
   logic [N-1:0]       resp_valid;
   logic [31:0]        resp_rdata;
   logic [AW-1:0]      mem_address;
   logic [3:0]         mem_byteena;
   logic [31:0]        mem_data;
   logic               mem_wren;
   logic [31:0]        mem_q;

   logic [31:0] mem     [256];
   logic [31:0] ref_mem [256];

   int n_checks = 0;
   int n_fail   = 0;

   int          m_ptr;
   bit          m_locked;
   int          m_owner;
   logic [31:0] m_rdata;
   int          g;

   data_memory_arbiter #(
      .NUM_REQ    (N),
      .ADDR_WIDTH (AW)
   ) dut (
      .i_clock       (clk),
      .i_reset_n     (rst_n),
      .i_req_valid   (tb_valid),
      .o_req_ready   (dut_ready),
      .i_req_addr    (tb_addr),
      .i_req_wren    (tb_wren),
      .i_req_byteena (tb_byteena),
      .i_req_wdata   (tb_wdata),
      .i_req_lock    (tb_lock),
      .o_resp_valid  (resp_valid),
      .o_resp_rdata  (resp_rdata),
      .o_mem_address (mem_address),
      .o_mem_byteena (mem_byteena),
      .o_mem_data    (mem_data),
      .o_mem_wren    (mem_wren),
      .i_mem_q       (mem_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] init_word(input int i);
      if (i == 32'h10) return 32'hDEADBEEF;
      if (i == 32'h20) return 32'h11223344;
      return 32'(i) * 32'h9E3779B1 + 32'h0F1E2D3C;
   endfunction

   // NOTE: the memory array has no reset; its contents are defined by this preload only.
   assign mem_q = mem[mem_address];
   initial begin
      for (int i = 0; i < 256; i++) mem[i] = init_word(i);
      forever begin
         @(posedge clk);
         if (mem_wren) begin
            for (int b = 0; b < 4; b++) begin
               if (mem_byteena[b]) mem[mem_address][8*b +: 8] <= mem_data[8*b +: 8];
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string pfx);
      check({pfx, "_ready"},   32'(dut_ready),   32'd0);
      check({pfx, "_rvalid"},  32'(resp_valid),  32'd0);
      check({pfx, "_rdata"},   resp_rdata,       32'd0);
      check({pfx, "_wren"},    32'(mem_wren),    32'd0);
      check({pfx, "_address"}, 32'(mem_address), 32'd0);
      check({pfx, "_byteena"}, 32'(mem_byteena), 32'd0);
      check({pfx, "_data"},    mem_data,         32'd0);
   endtask

   function automatic int mem_diffs();
      int n = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) n++;
      return n;
   endfunction

   task automatic model_reset();
      m_ptr    = 0;
      m_locked = 1'b0;
      m_owner  = 0;
      m_rdata  = 32'd0;
   endtask

   // Winner under the arbitration rules: locked owner only, else circular search from the pointer.
   function automatic int model_grant();
      if (m_locked) return tb_valid[m_owner] ? m_owner : -1;
      for (int k = 0; k < N; k++) begin
         int p;
         p = (m_ptr + k) % N;
         if (tb_valid[p]) return p;
      end
      return -1;
   endfunction

   // Called just after a falling edge with inputs already driven; returns at the next falling edge.
   task automatic do_cycle(output int gw);
      logic [31:0] exp_oh;
      int          a;
      gw     = model_grant();
      exp_oh = (gw >= 0) ? (32'd1 << gw) : 32'd0;
      #1;
      check("req_ready", 32'(dut_ready), exp_oh);
      if (gw >= 0) begin
         check("mem_wren",    32'(mem_wren),    32'(tb_wren[gw]));
         check("mem_address", 32'(mem_address), 32'(tb_addr[gw]));
         check("mem_byteena", 32'(mem_byteena), 32'(tb_byteena[gw]));
         check("mem_data",    mem_data,         tb_wdata[gw]);
      end else begin
         check("idle_wren",    32'(mem_wren),    32'd0);
         check("idle_address", 32'(mem_address), 32'd0);
      end
      @(posedge clk);
      if (gw >= 0) begin
         a = int'(tb_addr[gw]);
         if (tb_wren[gw]) begin
            for (int b = 0; b < 4; b++) begin
               if (tb_byteena[gw][b]) ref_mem[a][8*b +: 8] = tb_wdata[gw][8*b +: 8];
            end
         end else begin
            m_rdata = ref_mem[a];
         end
         m_ptr = (gw + 1) % N;
         if (!m_locked && tb_lock[gw]) begin
            m_locked = 1'b1;
            m_owner  = gw;
         end else if (m_locked && !tb_lock[gw]) begin
            m_locked = 1'b0;
         end
      end
      #1;
      check("resp_valid", 32'(resp_valid), exp_oh);
      check("resp_rdata", resp_rdata, m_rdata);
      @(negedge clk);
   endtask

   task automatic set_req(input int p, input logic [AW-1:0] addr, input logic wren,
                          input logic [3:0] be, input logic [31:0] wdata, input logic lock);
      tb_valid[p]   = 1'b1;
      tb_addr[p]    = addr;
      tb_wren[p]    = wren;
      tb_byteena[p] = be;
      tb_wdata[p]   = wdata;
      tb_lock[p]    = lock;
   endtask

   task automatic clear_req();
      tb_valid   = '0;
      tb_addr    = '0;
      tb_wren    = '0;
      tb_byteena = '0;
      tb_wdata   = '0;
      tb_lock    = '0;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
      model_reset();
      g = -1;

      // Reset with both requesters already valid: everything must read zero.
      clear_req();
      rst_n = 1'b0;
      set_req(0, 8'h05, 1'b1, 4'hF, 32'h12345678, 1'b0);
      set_req(1, 8'h06, 1'b1, 4'hF, 32'h9ABCDEF0, 1'b1);
      #2;
      check_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      clear_req();

      // Single read of a preloaded word.
      set_req(0, 8'h10, 1'b0, 4'h0, 32'd0, 1'b0);
      do_cycle(g);
      check("t1_resp_valid", 32'(resp_valid), 32'h1);
      check("t1_rdata", resp_rdata, 32'hDEADBEEF);
      clear_req();

      // Byte write from port 1, single acknowledgement pulse, then readback.
      set_req(1, 8'h20, 1'b1, 4'b0100, 32'hAABBCCDD, 1'b0);
      do_cycle(g);
      check("t3_wr_ack", 32'(resp_valid), 32'h2);
      clear_req();
      do_cycle(g);
      check("t3_ack_once", 32'(resp_valid), 32'h0);
      set_req(1, 8'h20, 1'b0, 4'h0, 32'd0, 1'b0);
      do_cycle(g);
      check("t3_rdata", resp_rdata, 32'h11BB3344);
      clear_req();

      // Locked read-modify-write by port 0 while port 1 waits.
      set_req(0, 8'h30, 1'b0, 4'h0, 32'd0, 1'b1);
      set_req(1, 8'h31, 1'b0, 4'h0, 32'd0, 1'b0);
      #1 check("t4_ready_a", 32'(dut_ready), 32'h1);
      do_cycle(g);
      set_req(0, 8'h30, 1'b1, 4'hF, init_word(32'h30) + 32'd1, 1'b0);
      #1 check("t4_ready_b", 32'(dut_ready), 32'h1);
      do_cycle(g);
      set_req(0, 8'h32, 1'b0, 4'h0, 32'd0, 1'b0);
      #1 check("t4_ready_c", 32'(dut_ready), 32'h2);
      do_cycle(g);
      check("t4_rdata_c", resp_rdata, init_word(32'h31));
      clear_req();
      set_req(0, 8'h30, 1'b0, 4'h0, 32'd0, 1'b0);
      do_cycle(g);
      check("t4_rmw_data", resp_rdata, init_word(32'h30) + 32'd1);
      clear_req();

      // Reset while locked, then a lone port 1 request is served at once.
      set_req(0, 8'h40, 1'b0, 4'h0, 32'd0, 1'b1);
      do_cycle(g);
      set_req(0, 8'h41, 1'b0, 4'h0, 32'd0, 1'b1);
      set_req(1, 8'h42, 1'b0, 4'h0, 32'd0, 1'b0);
      #1 check("t5_locked_stall", 32'(dut_ready), 32'h1);
      rst_n = 1'b0;
      #1;
      check_all_zero("t5_reset");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      clear_req();
      set_req(1, 8'h43, 1'b0, 4'h0, 32'd0, 1'b0);
      #1 check("t5_first_grant", 32'(dut_ready), 32'h2);
      do_cycle(g);
      check("t5_rdata", resp_rdata, init_word(32'h43));
      clear_req();

      // Contention: both ports continuously valid alternate 0,1,0,1,0,1.
      for (int i = 0; i < 6; i++) begin
         set_req(0, 8'(32'h50 + 2*i), 1'b0, 4'h0, 32'd0, 1'b0);
         set_req(1, 8'(32'h51 + 2*i), 1'b0, 4'h0, 32'd0, 1'b0);
         #1 check("t2_ready", 32'(dut_ready), (i % 2 == 0) ? 32'h1 : 32'h2);
         do_cycle(g);
         check("t2_resp_valid", 32'(resp_valid), (i % 2 == 0) ? 32'h1 : 32'h2);
      end
      clear_req();

      // Idle: nothing granted, nothing written.
      for (int i = 0; i < 5; i++) do_cycle(g);
      check("t6_mem_unchanged", 32'(mem_diffs()), 32'd0);

      // Randomized traffic; a stalled request keeps its fields stable.
      for (int c = 0; c < 400; c++) begin
         for (int p = 0; p < N; p++) begin
            if (!(tb_valid[p] && g != p)) begin
               tb_valid[p]   = ($urandom_range(0, 3) != 0);
               tb_addr[p]    = AW'($urandom_range(0, 7));
               tb_wren[p]    = 1'($urandom_range(0, 1));
               tb_byteena[p] = 4'($urandom);
               tb_wdata[p]   = $urandom;
               tb_lock[p]    = ($urandom_range(0, 3) == 0);
            end
         end
         do_cycle(g);
      end
      clear_req();
      do_cycle(g);
      check("final_mem_match", 32'(mem_diffs()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/data_memory_arbiter.md
Name: data_memory_arbiter

Overview:
- Shares the single-port data memory (word address, 4-bit byte enable, combinational read, synchronous byte-masked write) between NUM_REQ requesters, e.g. the core load/store unit (port 0) and a debug/DMA loader (port 1).
- Round-robin arbitration with valid/ready handshake and a bus lock for atomic read-modify-write.
- Returns registered read data one cycle after each accepted request.
- Sits between the requesters and the data memory instance.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- ADDR_WIDTH, `DATA_BITS-2, word-address width presented to memory.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  request pending, per requester.
- req_ready  out  NUM_REQ  request accepted this cycle when valid&ready.
- req_addr  in  NUM_REQ x ADDR_WIDTH  word address.
- req_wren  in  NUM_REQ  1 = write, 0 = read.
- req_byteena  in  NUM_REQ x 4  byte enables (writes only).
- req_wdata  in  NUM_REQ x 32  write data.
- req_lock  in  NUM_REQ  hold grant after this transfer.
- resp_valid  out  NUM_REQ  one-cycle pulse, response for the accepted request.
- resp_rdata  out  32  read data, shared, qualified by resp_valid.
- mem_address  out  ADDR_WIDTH  to memory address.
- mem_byteena  out  4  to memory byteena.
- mem_data  out  32  to memory data.
- mem_wren  out  1  to memory wren.
- mem_q  in  32  from memory q (combinational).

Behaviour:
Reset values (async on reset_n low): req_ready=0, resp_valid=0, resp_rdata=0, mem_wren=0, mem_address=0, mem_byteena=0, mem_data=0, rr_ptr=0, lock_owner invalid, state=ARB.

State machine:
- ARB: the grant winner is the first valid requester, searching circularly from rr_ptr.
  - req_ready is one-hot to the winner (combinational, same cycle); all zeros if no valid.
  - On handshake: rr_ptr <= winner+1 mod NUM_REQ.
  - If req_lock[winner] is set, go to LOCKED with lock_owner=winner.
- LOCKED: only lock_owner may receive ready. Other requesters stall even if valid.
  - Handshake with req_lock=0 releases the lock: next state ARB, rr_ptr <= owner+1.
  - Owner dropping valid without a transfer keeps the lock held.

Memory drive:
- mem_* are muxed combinationally from the granted requester's fields.
- mem_wren = handshake & req_wren[grant]; it is never 1 without a handshake.
- With no grant, mem_address/byteena/data are held at 0.

Response:
- On the edge ending a handshake cycle: resp_rdata <= mem_q (read) or unchanged (write); resp_valid <= onehot(grant).
- Fixed latency of 1 cycle for both reads and writes. Writes also pulse resp_valid as an acknowledgement.
- resp_valid is zero in all other cycles.

Throughput and ordering:
- One transfer per cycle; back-to-back transfers are allowed, including from the same requester.
- A read issued the cycle after a write to the same address returns the new data, because the memory write has completed at the edge.

Boundary and edge cases:
- A single valid requester is granted immediately regardless of rr_ptr.
- rr_ptr wraps from NUM_REQ-1 to 0.
- Requesters must hold the address, data and control fields stable while valid&!ready.
- Reset asserted mid-lock clears the lock and any pending resp_valid. An in-flight write in the reset cycle is not guaranteed.

Decomposition:
- Shared package: the request struct (addr, wren, byteena, wdata, lock) and the ARB/LOCKED state enum.
- One natural sub-module: rr_arbiter. Inputs req[NUM_REQ] and ptr; output a one-hot grant (combinational priority rotate). It is reusable for a future instruction/data port arbiter.

Test Plan:
1. Single read: memory word 0x10 = 0xDEADBEEF; port0 read addr 0x10 → ready0 the same cycle, next cycle resp_valid=01 and resp_rdata=0xDEADBEEF.
2. Contention fairness: both ports are continuously valid for 6 cycles after reset → grants alternate 0,1,0,1,0,1, and resp_valid alternates with 1-cycle lag.
3. Byte write: port1 writes 0xAABBCCDD, byteena=0100, to a word holding 0x11223344 → the following read returns 0x11BB3344, and write resp_valid=10 pulses once.
4. Lock RMW: port0 reads with lock=1 while port1 is valid → port1 is stalled 2 cycles. Port0 then writes with lock=0, port1 is granted the cycle after, and rr_ptr=1.
5. Reset mid-lock: reset_n low while LOCKED → all outputs go to 0 immediately (async). After release, port1 alone is valid and is granted on the first cycle.
6. Idle: no valid for 5 cycles → req_ready=0, mem_wren=0, resp_valid=0 throughout, and memory contents are unchanged.
